// File: rtl/seg7_scan_controller.sv
// Multiplexed seven-segment controller: captures a binary result, converts it to BCD
// with a sequential shift-add-3 engine and scans it across common-anode digits.
module seg7_scan_controller #(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WIDTH-1:0]  value,
   input  logic              is_signed,
   input  logic              blank_zeros,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              busy,
   output logic              overflow
);

   // WIDTH/3+1 nibbles always hold 2**WIDTH-1 because 2**3 < 10.
   localparam int NIB = WIDTH / 3 + 1;
   localparam int BW  = NIB * 4;
   localparam int EXT = (NIB > DIGITS) ? NIB : DIGITS;
   localparam int EW  = EXT * 4;
   localparam int CW  = $clog2(WIDTH);
   localparam int RW  = $clog2(REFRESH_DIV);
   localparam int IW  = $clog2(DIGITS);

   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < NIB; i++) begin
         r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
      end
      return r;
   endfunction

   function automatic logic ovf_of(input logic [BW-1:0] b, input logic n);
      logic o;
      int   cap;
      o   = 1'b0;
      cap = n ? (DIGITS - 1) : DIGITS;
      for (int i = 0; i < NIB; i++) begin
         o = o | ((i >= cap) && (b[i*4 +: 4] != 4'd0));
      end
      return o;
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   state_t           state_q;
   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [BW-1:0]    bcd_q;
   logic [WIDTH-1:0] mag_q;
   logic             neg_q;
   logic             blank_q;
   logic [EW-1:0]    disp_q;
   logic             disp_neg_q;
   logic             disp_blank_q;
   logic             ovf_q;
   logic [RW-1:0]    rcnt_q, rcnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [BW-1:0]    bcd_adj;

   assign bcd_adj = add3(bcd_q);

   // Conversion FSM; the display register only changes in COMMIT so a reset mid-run drops the partial result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
         bcd_q        <= '0;
         mag_q        <= '0;
         neg_q        <= 1'b0;
         blank_q      <= 1'b0;
         disp_q       <= '0;
         disp_neg_q   <= 1'b0;
         disp_blank_q <= 1'b1;
         ovf_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  mag_q   <= (is_signed && value[WIDTH-1]) ? (-value) : value;
                  neg_q   <= is_signed && value[WIDTH-1];
                  blank_q <= blank_zeros;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CONVERT;
               end else begin
                  state_q <= IDLE;
               end
            end
            CONVERT: begin
               bcd_q <= {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
               mag_q <= {mag_q[WIDTH-2:0], 1'b0};
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= COMMIT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            COMMIT: begin
               disp_q       <= EW'(bcd_q);
               disp_neg_q   <= neg_q;
               disp_blank_q <= blank_q;
               ovf_q        <= ovf_of(bcd_q, neg_q);
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Refresh counter and digit index next-state.
   always_comb begin
      rcnt_d = rcnt_q + RW'(1);
      idx_d  = idx_q;
      if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
         rcnt_d = '0;
         idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : (idx_q + IW'(1));
      end else begin
         idx_d  = idx_q;
      end
   end

   // Scanner state, free running regardless of the FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt_q <= '0;
         idx_q  <= '0;
      end else begin
         rcnt_q <= rcnt_d;
         idx_q  <= idx_d;
      end
   end

   int         msnz;
   int         k;
   logic [3:0] cur;

   // Segment decode of the currently scanned digit.
   always_comb begin
      msnz = 0;
      for (int i = 0; i < DIGITS; i++) begin
         msnz = (disp_q[i*4 +: 4] != 4'd0) ? i : msnz;
      end
      k   = int'(idx_q);
      cur = disp_q[k*4 +: 4];
      if (ovf_q) begin
         seg = SEG_MINUS;
      end else if (disp_blank_q && (k > msnz)) begin
         seg = (disp_neg_q && (k == msnz + 1)) ? SEG_MINUS : SEG_BLANK;
      end else if (!disp_blank_q && disp_neg_q && (k == DIGITS - 1)) begin
         seg = SEG_MINUS;
      end else begin
         seg = seg_of(cur);
      end
   end

   assign an       = ~(DIGITS'(1) << idx_q);
   assign busy     = busy_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: expected frames queued at load, checked after busy drops.
module tb_seg7_scan_controller;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] MI = 7'b0111111;
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] NA = 7'h55;

   logic       clk = 1'b0;
   logic       reset, load4, load3, is_signed, blank_zeros;
   logic [7:0] value;
   logic [6:0] seg4, seg3;
   logic [3:0] an4;
   logic [2:0] an3;
   logic       busy4, busy3, ovf4, ovf3;

   always #5 clk = ~clk;

   seg7_scan_controller #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4)) u_dut4 (
      .clk(clk), .reset(reset), .load(load4), .value(value), .is_signed(is_signed),
      .blank_zeros(blank_zeros), .seg(seg4), .an(an4), .busy(busy4), .overflow(ovf4));

   seg7_scan_controller #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) u_dut3 (
      .clk(clk), .reset(reset), .load(load3), .value(value), .is_signed(is_signed),
      .blank_zeros(blank_zeros), .seg(seg3), .an(an3), .busy(busy3), .overflow(ovf3));

   typedef struct {
      string       tag;
      bit          sel3;
      logic [27:0] segs;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input bit sel3, input logic [6:0] d3, input logic [6:0] d2,
                       input logic [6:0] d1, input logic [6:0] d0, input logic ovf);
      exp_t e;
      e.tag  = tag;
      e.sel3 = sel3;
      e.segs = {d3, d2, d1, d0};
      e.ovf  = ovf;
      sb.push_back(e);
   endtask

   task automatic do_load(input bit sel3, input logic [7:0] v, input bit sg, input bit bz);
      value       = v;
      is_signed   = sg;
      blank_zeros = bz;
      if (sel3) load3 = 1'b1;
      else      load4 = 1'b1;
      step();
      load3 = 1'b0;
      load4 = 1'b0;
   endtask

   task automatic wait_done(input bit sel3, output int cycles);
      cycles = 0;
      while ((sel3 ? busy3 : busy4) && cycles < 100) begin
         step();
         cycles++;
      end
   endtask

   task automatic capture(input bit sel3, output logic [27:0] fr);
      logic [3:0] a, m;
      logic [6:0] s;
      fr = {4{NA}};
      for (int i = 0; i < 16; i++) begin
         a = sel3 ? {1'b1, an3} : an4;
         s = sel3 ? seg3 : seg4;
         for (int d = 0; d < 4; d++) begin
            m = 4'b0001 << d;
            if (a == ~m) fr[d*7 +: 7] = s;
         end
         step();
      end
   endtask

   task automatic check_result();
      exp_t        e;
      logic [27:0] fr;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         capture(e.sel3, fr);
         check({e.tag, " digits"}, {4'd0, fr}, {4'd0, e.segs});
         check({e.tag, " overflow"}, {31'd0, (e.sel3 ? ovf3 : ovf4)}, {31'd0, e.ovf});
      end
   endtask

   initial begin
      int         c;
      int         idx;
      logic [3:0] exp_an;

      reset = 1'b1; load4 = 1'b0; load3 = 1'b0;
      value = 8'd0; is_signed = 1'b0; blank_zeros = 1'b0;
      step();
      step();
      reset = 1'b0;

      check("rst busy", {31'd0, busy4}, 32'd0);
      check("rst overflow", {31'd0, ovf4}, 32'd0);
      check("rst an", {28'd0, an4}, 32'hE);
      check("rst seg", {25'd0, seg4}, {25'd0, S0});
      check("rst an3", {29'd0, an3}, 32'h6);
      for (int n = 1; n <= 16; n++) begin
         step();
         idx    = (n / 4) % 4;
         exp_an = ~(4'b0001 << idx);
         check("scan an", {28'd0, an4}, {28'd0, exp_an});
         check("scan seg", {25'd0, seg4}, {25'd0, (idx == 0) ? S0 : BL});
      end
      check("idle busy", {31'd0, busy4}, 32'd0);

      push("u173", 1'b0, BL, S1, S7, S3, 1'b0);
      do_load(1'b0, 8'd173, 1'b0, 1'b1);
      wait_done(1'b0, c);
      check("u173 busy cycles", c, 32'd9);
      check_result();

      push("neg10 blank", 1'b0, BL, MI, S1, S0, 1'b0);
      do_load(1'b0, 8'hF6, 1'b1, 1'b1);
      wait_done(1'b0, c);
      check("neg10 busy cycles", c, 32'd9);
      check_result();

      push("neg10 noblank", 1'b0, MI, S0, S1, S0, 1'b0);
      do_load(1'b0, 8'hF6, 1'b1, 1'b0);
      wait_done(1'b0, c);
      check_result();

      push("u255 noblank", 1'b0, S0, S2, S5, S5, 1'b0);
      do_load(1'b0, 8'd255, 1'b0, 1'b0);
      wait_done(1'b0, c);
      check_result();

      push("load ignored", 1'b0, BL, BL, S4, S2, 1'b0);
      do_load(1'b0, 8'd42, 1'b0, 1'b1);
      step();
      step();
      do_load(1'b0, 8'd99, 1'b0, 1'b1);
      check("busy during 2nd load", {31'd0, busy4}, 32'd1);
      wait_done(1'b0, c);
      check("ignored busy remain", c, 32'd6);
      check_result();

      push("d3 -128", 1'b1, NA, MI, MI, MI, 1'b1);
      do_load(1'b1, 8'h80, 1'b1, 1'b1);
      wait_done(1'b1, c);
      check("d3 busy cycles", c, 32'd9);
      check_result();

      push("d3 u255", 1'b1, NA, S2, S5, S5, 1'b0);
      do_load(1'b1, 8'd255, 1'b0, 1'b1);
      wait_done(1'b1, c);
      check_result();

      push("reset abort", 1'b0, BL, BL, BL, S0, 1'b0);
      do_load(1'b0, 8'd42, 1'b0, 1'b1);
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort busy", {31'd0, busy4}, 32'd0);
      check("abort an", {28'd0, an4}, 32'hE);
      for (int n = 0; n < 12; n++) step();
      check_result();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Parametrised multiplexed seven-segment display controller for the ALU board. It captures a WIDTH-bit ALU result on a load strobe and converts it to decimal with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the result across DIGITS common-anode digits, with optional leading-zero blanking, a minus sign for signed results, and overflow indication. It sits between the ALU result register and the board's segment/anode pins.

## Interface
- WIDTH, 8: bit width of the input value (≥ 2).
- DIGITS, 4: number of physical digits (≥ 2).
- REFRESH_DIV, 50000: clock cycles each digit stays lit (≥ 2).
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures value/is_signed/blank_zeros when not busy.
- value  input  WIDTH  result to display.
- is_signed  input  1  1: value is two's complement; 0: unsigned.
- blank_zeros  input  1  1: blank leading zeros.
- seg  output  7  {g,f,e,d,c,b,a}, active low.
- an  output  DIGITS  digit enables, active low, one-hot-zero; an[0] is the rightmost (least significant) digit.
- busy  output  1  conversion in progress.
- overflow  output  1  committed value does not fit on DIGITS digits.

## Operation
- FSM states are IDLE, CONVERT and COMMIT.
- IDLE: on load, latch mag = |value| as a WIDTH-bit unsigned quantity (sign applies only if is_signed and value[WIDTH-1]), latch neg, blank_zeros and a cleared BCD register, then go to CONVERT.
- CONVERT: runs exactly WIDTH cycles. Each cycle adds 3 to every BCD nibble ≥ 5, then shifts {bcd, mag} left by 1. The BCD register holds enough nibbles for any WIDTH-bit magnitude.
- COMMIT: one cycle. Copies the result into the display register atomically, sets overflow, then returns to IDLE.
- load is ignored outside IDLE. Load and reset in the same cycle: reset wins.
- Capacity is DIGITS decimal digits when non-negative and DIGITS-1 when negative (the sign occupies one digit). overflow = 1 if any BCD nibble at or above capacity is nonzero.
- Display mapping with overflow = 1: every digit shows minus.
- Display mapping otherwise:
  - Digit k shows BCD nibble k.
  - If blank_zeros = 1, digits above the most significant nonzero nibble are blank, and digit 0 is never blanked.
  - If neg: with blank_zeros = 1 the minus sits in the first blank position left of the number; with blank_zeros = 0 it sits in digit DIGITS-1 and zeros fill the rest.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, blank=1111111.
- Scanner: a refresh counter runs 0..REFRESH_DIV-1 and wraps. On wrap, digit index idx advances modulo DIGITS (DIGITS-1 → 0). Scanning runs continuously, independent of the FSM.
- an = ~(1 << idx). seg is decoded combinationally from idx and the display register.
- The display keeps showing the previous value until COMMIT.

## Timing
- Reset values:
  - FSM in IDLE, busy = 0, overflow = 0.
  - Display register = 0 (non-negative, blank_zeros = 1), so the display shows "0".
  - idx = 0 and counter = 0, so an = ~1 and seg = 1000000.
- Load sampled at edge t: busy = 1 from t+1 through t+WIDTH+1 (WIDTH CONVERT cycles plus COMMIT). New display and overflow are visible from t+WIDTH+2, when busy = 0 again.
- Earliest accepted next load is sampled at edge t+WIDTH+2.
- Reset during CONVERT/COMMIT aborts the conversion: the display and all state take reset values on the next cycle, and no partial result is ever committed.
- Each digit is enabled for exactly REFRESH_DIV cycles. A full frame is DIGITS×REFRESH_DIV cycles.

## Test plan
All scenarios use WIDTH=8, DIGITS=4, REFRESH_DIV=4 unless stated.
- Reset, then hold 16 cycles -> busy=0, overflow=0. an steps 1110, 1101, 1011, 0111 every 4 cycles and wraps to 1110. seg = 1000000 while an=1110 and 1111111 on the other digits.
- load value=173, is_signed=0, blank_zeros=1 -> busy high for 9 cycles. Digits 3..0 then show blank, 1111001, 1111000, 0110000, and overflow=0.
- load value=8'hF6, is_signed=1, blank_zeros=1 -> digits 3..0 show blank, minus, 1, 0. The same load with blank_zeros=0 -> minus, 0, 1, 0.
- DIGITS=3: load 8'h80, is_signed=1 (-128) -> overflow=1 and all digits show minus. Then load 255, is_signed=0 -> overflow=0 and display shows 2, 5, 5.
- load 42, then pulse load with 99 three cycles later (while busy) -> the second load is ignored and the display shows 42.
- load 42, then assert reset 4 cycles later -> next cycle busy=0 and the display shows "0". The value 42 never appears.
